// File: rtl/writeback_packer.sv
// Register-bank writeback packer: word writes, MSB-first byte packing with pad-and-flush, optional vector byte path.
// Define WB_VECTOR_EN to enable vector-byte writes; otherwise vector beats are dropped like reserved beats.
`timescale 1ns/1ps
module writeback_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_mode,
  input  logic [3:0]  in_Rg,
  input  logic [31:0] in_data,
  input  logic [7:0]  in_pix,
  input  logic        flush,
  output logic        WE_C,
  output logic [3:0]  Rg_WB,
  output logic [31:0] DinC,
  output logic        WE_V,
  output logic [7:0]  DinV_8bit,
  output logic [1:0]  pack_count
);

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_PACK = 2'b01;
  localparam logic [1:0] MODE_VEC  = 2'b10;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  prg_q, prg_d;
  logic        we_c_q, we_c_d;
  logic [3:0]  rg_wb_q, rg_wb_d;
  logic [31:0] dinc_q, dinc_d;
`ifdef WB_VECTOR_EN
  logic        we_v_q, we_v_d;
  logic [7:0]  dinv_q, dinv_d;
`endif

  logic is_pack;
  logic need_flush;
  logic accept;
  logic flush_now;

  // Byte 0 of a pack lands in the top lane, byte 3 in the bottom lane.
  function automatic logic [31:0] place_byte(input logic [31:0] acc,
                                             input logic [1:0]  cnt,
                                             input logic [7:0]  pix);
    logic [31:0] w;
    w = acc;
    case (cnt)
      2'd0:    w[31:24] = pix;
      2'd1:    w[23:16] = pix;
      2'd2:    w[15:8]  = pix;
      default: w[7:0]   = pix;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] pad_word(input logic [31:0] acc,
                                           input logic [1:0]  cnt);
    logic [31:0] w;
    w = acc;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(cnt)) w[31-8*i -: 8] = PAD_BYTE;
    end
    return w;
  endfunction

  assign is_pack = (in_mode == MODE_PACK);

  // A partial pack must be written out before any non-pack beat or an explicit
  // flush, except when the flush rides on the beat that completes the word.
  assign need_flush = (in_valid && !is_pack) ||
                      (flush && !(in_valid && is_pack && cnt_q == 2'd3));

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        S_PARTIAL: in_ready = !need_flush;
        default:   in_ready = 1'b1;
      endcase
    end
  end

  assign accept    = in_valid && in_ready;
  assign flush_now = (state_q == S_PARTIAL) && need_flush;

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PARTIAL: begin
        if (need_flush)                             state_d = S_FLUSH;
        else if (accept && is_pack && cnt_q == 2'd3) state_d = S_EMPTY;
      end
      default: state_d = (accept && is_pack) ? S_PARTIAL : S_EMPTY;
    endcase
  end

  // ---- output / datapath next values ----
  // The accumulator is already cleared on entry to FLUSH, so FLUSH accepts beats exactly like EMPTY.
  always_comb begin
    we_c_d  = 1'b0;
    rg_wb_d = rg_wb_q;
    dinc_d  = dinc_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prg_d   = prg_q;
`ifdef WB_VECTOR_EN
    we_v_d  = 1'b0;
    dinv_d  = dinv_q;
`endif
    if (flush_now) begin
      we_c_d  = 1'b1;
      rg_wb_d = prg_q;
      dinc_d  = pad_word(acc_q, cnt_q);
      acc_d   = '0;
      cnt_d   = 2'd0;
    end else if (accept) begin
      case (in_mode)
        MODE_WORD: begin
          we_c_d  = 1'b1;
          rg_wb_d = in_Rg;
          dinc_d  = in_data;
        end
        MODE_PACK: begin
          if (cnt_q == 2'd3) begin
            we_c_d  = 1'b1;
            rg_wb_d = in_Rg;
            dinc_d  = place_byte(acc_q, cnt_q, in_pix);
            acc_d   = '0;
            cnt_d   = 2'd0;
          end else begin
            acc_d = place_byte(acc_q, cnt_q, in_pix);
            cnt_d = cnt_q + 2'd1;
            prg_d = in_Rg;
          end
        end
`ifdef WB_VECTOR_EN
        MODE_VEC: begin
          we_v_d = 1'b1;
          dinv_d = in_pix;
        end
`endif
        default: ;
      endcase
    end
  end

  // ---- output and accumulator registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= 2'd0;
      prg_q   <= '0;
      we_c_q  <= 1'b0;
      rg_wb_q <= '0;
      dinc_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prg_q   <= prg_d;
      we_c_q  <= we_c_d;
      rg_wb_q <= rg_wb_d;
      dinc_q  <= dinc_d;
    end
  end

`ifdef WB_VECTOR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_v_q <= 1'b0;
      dinv_q <= '0;
    end else begin
      we_v_q <= we_v_d;
      dinv_q <= dinv_d;
    end
  end

  assign WE_V      = we_v_q;
  assign DinV_8bit = dinv_q;
`else
  assign WE_V      = 1'b0;
  assign DinV_8bit = 8'h00;
`endif

  assign WE_C       = we_c_q;
  assign Rg_WB      = rg_wb_q;
  assign DinC       = dinc_q;
  assign pack_count = cnt_q;

endmodule

// File: tb/tb_writeback_packer.sv
// Directed table-driven bench for writeback_packer plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_writeback_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [3:0]  in_Rg;
  logic [31:0] in_data;
  logic [7:0]  in_pix;
  logic        flush;
  logic        WE_C;
  logic [3:0]  Rg_WB;
  logic [31:0] DinC;
  logic        WE_V;
  logic [7:0]  DinV_8bit;
  logic [1:0]  pack_count;

  int n_chk;
  int n_pass;

`ifdef WB_VECTOR_EN
  localparam logic VEC_ON = 1'b1;
`else
  localparam logic VEC_ON = 1'b0;
`endif

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] V = 2'b10;
  localparam logic [1:0] R = 2'b11;

  writeback_packer #(.PAD_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_Rg      (in_Rg),
    .in_data    (in_data),
    .in_pix     (in_pix),
    .flush      (flush),
    .WE_C       (WE_C),
    .Rg_WB      (Rg_WB),
    .DinC       (DinC),
    .WE_V       (WE_V),
    .DinV_8bit  (DinV_8bit),
    .pack_count (pack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  mode;
    logic [3:0]  rg;
    logic [31:0] data;
    logic [7:0]  pix;
    logic        fl;
    logic        rdy;
    logic        wec;
    logic [3:0]  rgwb;
    logic [31:0] dinc;
    logic        wev;
    logic [7:0]  dinv;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vld, input logic [1:0] mode, input logic [3:0] rg,
                              input logic [31:0] data, input logic [7:0] pix, input logic fl,
                              input logic rdy, input logic wec, input logic [3:0] rgwb,
                              input logic [31:0] dinc, input logic wev, input logic [7:0] dinv,
                              input logic [1:0] cnt);
    vec_t v;
    v.vld = vld; v.mode = mode; v.rg = rg; v.data = data; v.pix = pix; v.fl = fl;
    v.rdy = rdy; v.wec = wec; v.rgwb = rgwb; v.dinc = dinc; v.wev = wev; v.dinv = dinv;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // One cycle: drive at negedge, check in_ready before the edge, registered outputs after it.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    in_valid = v.vld;
    in_mode  = v.mode;
    in_Rg    = v.rg;
    in_data  = v.data;
    in_pix   = v.pix;
    flush    = v.fl;
    #1;
    check($sformatf("%s.in_ready", nm), 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    check($sformatf("%s.WE_C", nm), 32'(WE_C), 32'(v.wec));
    check($sformatf("%s.WE_V", nm), 32'(WE_V), 32'(v.wev));
    check($sformatf("%s.pack_count", nm), 32'(pack_count), 32'(v.cnt));
    if (v.wec) begin
      check($sformatf("%s.Rg_WB", nm), 32'(Rg_WB), 32'(v.rgwb));
      check($sformatf("%s.DinC", nm), DinC, v.dinc);
    end
    if (v.wev) check($sformatf("%s.DinV_8bit", nm), 32'(DinV_8bit), 32'(v.dinv));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_mode  = W;
    in_Rg    = 4'd0;
    in_data  = 32'd0;
    in_pix   = 8'd0;
    flush    = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    check($sformatf("%s.WE_C", nm), 32'(WE_C), 32'd0);
    check($sformatf("%s.WE_V", nm), 32'(WE_V), 32'd0);
    check($sformatf("%s.Rg_WB", nm), 32'(Rg_WB), 32'd0);
    check($sformatf("%s.DinC", nm), DinC, 32'd0);
    check($sformatf("%s.DinV_8bit", nm), 32'(DinV_8bit), 32'd0);
    check($sformatf("%s.pack_count", nm), 32'(pack_count), 32'd0);
    check($sformatf("%s.in_ready", nm), 32'(in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle_inputs();
    rst = 1'b0;

    //          vld mode rg  data          pix    fl  rdy wec rgwb dinc          wev     dinv   cnt
    tbl.push_back(mk(1, W, 3, 32'hDEADBEEF, 8'h00, 0, 1, 1, 3, 32'hDEADBEEF, 0, 8'h00, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(1, P, 5, 32'h0,        8'h11, 0, 1, 0, 0, 32'h0,        0, 8'h00, 1));
    tbl.push_back(mk(1, P, 5, 32'h0,        8'h22, 0, 1, 0, 0, 32'h0,        0, 8'h00, 2));
    tbl.push_back(mk(1, P, 5, 32'h0,        8'h33, 0, 1, 0, 0, 32'h0,        0, 8'h00, 3));
    tbl.push_back(mk(1, P, 5, 32'h0,        8'h44, 0, 1, 1, 5, 32'h11223344, 0, 8'h00, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 1, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(1, V, 9, 32'h0,        8'h5C, 0, 1, 0, 0, 32'h0,   VEC_ON, 8'h5C, 0));
    tbl.push_back(mk(1, R, 4, 32'hFFFFFFFF, 8'hEE, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(1, P, 7, 32'h0,        8'hAA, 0, 1, 0, 0, 32'h0,        0, 8'h00, 1));
    tbl.push_back(mk(1, P, 7, 32'h0,        8'hBB, 0, 1, 0, 0, 32'h0,        0, 8'h00, 2));
    tbl.push_back(mk(1, W, 9, 32'h12345678, 8'h00, 0, 0, 1, 7, 32'hAABB0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, W, 9, 32'h12345678, 8'h00, 0, 1, 1, 9, 32'h12345678, 0, 8'h00, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(1, P, 2, 32'h0,        8'h01, 0, 1, 0, 0, 32'h0,        0, 8'h00, 1));
    tbl.push_back(mk(1, P, 2, 32'h0,        8'h02, 0, 1, 0, 0, 32'h0,        0, 8'h00, 2));
    tbl.push_back(mk(1, P, 2, 32'h0,        8'h03, 0, 1, 0, 0, 32'h0,        0, 8'h00, 3));
    tbl.push_back(mk(1, P, 2, 32'h0,        8'h04, 1, 1, 1, 2, 32'h01020304, 0, 8'h00, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(1, P, 4, 32'h0,        8'hC1, 0, 1, 0, 0, 32'h0,        0, 8'h00, 1));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 1, 0, 1, 4, 32'hC1000000, 0, 8'h00, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));
    tbl.push_back(mk(1, P, 6, 32'h0,        8'hD1, 0, 1, 0, 0, 32'h0,        0, 8'h00, 1));
    tbl.push_back(mk(1, V, 0, 32'h0,        8'h77, 0, 0, 1, 6, 32'hD1000000, 0, 8'h00, 0));
    tbl.push_back(mk(1, V, 0, 32'h0,        8'h77, 0, 1, 0, 0, 32'h0,   VEC_ON, 8'h77, 0));
    tbl.push_back(mk(0, W, 0, 32'h0,        8'h00, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0));

    #1 rst = 1'b1;
    #1 check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset in the middle of a pack: nothing is written and the next pack starts clean.
    run_vec(mk(1, P, 1, 32'h0, 8'hA1, 0, 1, 0, 0, 32'h0, 0, 8'h00, 1), "rp0");
    run_vec(mk(1, P, 1, 32'h0, 8'hA2, 0, 1, 0, 0, 32'h0, 0, 8'h00, 2), "rp1");
    idle_inputs();
    #1 rst = 1'b1;
    #1 check_reset_state("midrst");
    @(posedge clk);
    #1 check("midrst.WE_C_hold", 32'(WE_C), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, W, 0, 32'h0, 8'h00, 0, 1, 0, 0, 32'h0, 0, 8'h00, 0), "rq0");
    run_vec(mk(1, P, 1, 32'h0, 8'hB1, 0, 1, 0, 0, 32'h0, 0, 8'h00, 1), "rq1");
    run_vec(mk(1, P, 1, 32'h0, 8'hB2, 0, 1, 0, 0, 32'h0, 0, 8'h00, 2), "rq2");
    run_vec(mk(1, P, 1, 32'h0, 8'hB3, 0, 1, 0, 0, 32'h0, 0, 8'h00, 3), "rq3");
    run_vec(mk(1, P, 1, 32'h0, 8'hB4, 0, 1, 1, 1, 32'hB1B2B3B4, 0, 8'h00, 0), "rq4");
    run_vec(mk(0, W, 0, 32'h0, 8'h00, 0, 1, 0, 0, 32'h0, 0, 8'h00, 0), "rq5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
